// File: rtl/sha256_block_packer.sv
// Packs a UART byte stream into padded 512-bit SHA-256 message blocks.
// A message ends on in_last or after IDLE_TIMEOUT idle cycles.
module sha256_block_packer #(
   parameter int LEN_W        = 64,
   parameter int IDLE_TIMEOUT = 2000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [511:0]     blk_data,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic             blk_first,
   output logic             blk_last,
   output logic [LEN_W-4:0] msg_bytes,
   output logic             len_err
);

   localparam logic [1:0] S_FILL = 2'd0;
   localparam logic [1:0] S_PAD  = 2'd1;
   localparam logic [1:0] S_LEN  = 2'd2;
   localparam logic [1:0] S_EMIT = 2'd3;

   localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

   logic [1:0]       state;
   logic [6:0]       idx;
   logic [LEN_W-4:0] byte_cnt;
   logic [IW-1:0]    idle_cnt;
   logic             first_pend;
   logic             pad_pend;
   logic             len_pend;
   logic             last_q;
   logic             run;

   logic             accept;
   logic [LEN_W-3:0] cnt_inc;
   logic [63:0]      bit_len;
   logic             timeout_hit;

   assign accept      = in_valid && in_ready;
   assign cnt_inc     = {1'b0, byte_cnt} + 1'b1;
   assign bit_len     = 64'({byte_cnt, 3'b000});
   assign timeout_hit = (IDLE_TIMEOUT > 0) && (byte_cnt != '0) &&
                        (idle_cnt == IW'(IDLE_TIMEOUT));

   // run keeps in_ready low while rst is asserted even though state is S_FILL.
   assign in_ready  = run && (state == S_FILL);
   assign blk_valid = (state == S_EMIT);
   assign blk_first = first_pend && blk_valid;
   assign blk_last  = last_q;
   assign msg_bytes = byte_cnt;

   // NOTE: the block buffer is reset because blk_data is an observable output with a defined reset value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FILL;
         idx        <= '0;
         byte_cnt   <= '0;
         idle_cnt   <= '0;
         first_pend <= 1'b1;
         pad_pend   <= 1'b0;
         len_pend   <= 1'b0;
         last_q     <= 1'b0;
         run        <= 1'b0;
         len_err    <= 1'b0;
         blk_data   <= '0;
      end else begin
         run <= 1'b1;
         case (state)
            S_FILL: begin
               if (accept) begin
                  blk_data[511 - 8*int'(idx) -: 8] <= in_data;
                  idx      <= idx + 7'd1;
                  byte_cnt <= cnt_inc[LEN_W-4:0];
                  idle_cnt <= '0;
                  if (first_pend && idx == 7'd0) len_err <= cnt_inc[LEN_W-3];
                  else if (cnt_inc[LEN_W-3])     len_err <= 1'b1;
                  if (idx == 7'd63) begin
                     state    <= S_EMIT;
                     last_q   <= 1'b0;
                     pad_pend <= in_last;
                  end else if (in_last) begin
                     state <= S_PAD;
                  end
               end else if (timeout_hit) begin
                  state    <= S_PAD;
                  idle_cnt <= '0;
               end else if (byte_cnt != '0) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            S_PAD: begin
               blk_data[511 - 8*int'(idx) -: 8] <= 8'h80;
               for (int i = 0; i < 64; i++) begin
                  if (i > int'(idx)) blk_data[511 - 8*i -: 8] <= 8'h00;
               end
               // The length only fits if it does not collide with the 0x80 marker.
               if (idx <= 7'd55) begin
                  blk_data[63:0] <= bit_len;
                  last_q         <= 1'b1;
               end else begin
                  len_pend <= 1'b1;
                  last_q   <= 1'b0;
               end
               state <= S_EMIT;
            end
            S_LEN: begin
               blk_data <= {448'b0, bit_len};
               last_q   <= 1'b1;
               state    <= S_EMIT;
            end
            default: begin
               if (blk_ready) begin
                  blk_data   <= '0;
                  idx        <= '0;
                  first_pend <= 1'b0;
                  last_q     <= 1'b0;
                  if (pad_pend) begin
                     pad_pend <= 1'b0;
                     state    <= S_PAD;
                  end else if (len_pend) begin
                     len_pend <= 1'b0;
                     state    <= S_LEN;
                  end else if (last_q) begin
                     byte_cnt   <= '0;
                     first_pend <= 1'b1;
                     state      <= S_FILL;
                  end else begin
                     state <= S_FILL;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_block_packer.sv
// Directed bench for sha256_block_packer with hand-built expected blocks.
// Runs with IDLE_TIMEOUT=100 so the timeout path is reachable quickly.
module tb_sha256_block_packer;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [511:0] blk_data;
   logic         blk_valid;
   logic         blk_ready;
   logic         blk_first;
   logic         blk_last;
   logic [60:0]  msg_bytes;
   logic         len_err;

   int errors = 0;
   int checks = 0;

   logic [511:0] exp_abc;
   logic [511:0] d;
   logic [511:0] held;
   logic         f, l;
   logic [60:0]  n;

   sha256_block_packer #(.LEN_W(64), .IDLE_TIMEOUT(100)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_first (blk_first),
      .blk_last  (blk_last),
      .msg_bytes (msg_bytes),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a clock edge; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input logic last);
      int t = 0;
      in_data  = b;
      in_valid = 1'b1;
      in_last  = last;
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic recv_block(output logic [511:0] data, output logic first,
                             output logic last, output logic [60:0] bytes);
      int t = 0;
      while (!blk_valid && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!blk_valid) check("recv_timeout", 0, 1);
      data  = blk_data;
      first = blk_first;
      last  = blk_last;
      bytes = msg_bytes;
      blk_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_abc(input logic last_flag);
      send_byte(8'h61, 1'b0);
      send_byte(8'h62, 1'b0);
      send_byte(8'h63, last_flag);
   endtask

   initial begin
      int lat;
      logic seen, bad;
      exp_abc   = {24'h616263, 8'h80, 416'h0, 64'h18};
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      blk_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_blk_valid", blk_valid, 0);
      check("rst_blk_data", blk_data, 0);
      check("rst_flags", {blk_first, blk_last, len_err}, 0);
      check("rst_msg_bytes", msg_bytes, 0);
      @(negedge clk);
      rst = 1'b0;

      // No bytes sent: the timeout must not produce an empty message.
      seen = 1'b0;
      repeat (250) begin
         @(negedge clk);
         if (blk_valid) seen = 1'b1;
      end
      check("empty_no_block", seen, 0);
      check("idle_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      send_abc(1'b1);
      recv_block(d, f, l, n);
      check("abc_data", d, exp_abc);
      check("abc_first_last", {f, l}, 2'b11);
      check("abc_msg_bytes", n, 3);

      for (int i = 0; i < 55; i++) send_byte(8'h41, i == 54);
      recv_block(d, f, l, n);
      check("b55_data", d, {{55{8'h41}}, 8'h80, 64'h1B8});
      check("b55_first_last", {f, l}, 2'b11);
      check("b55_msg_bytes", n, 55);

      for (int i = 0; i < 56; i++) send_byte(8'h41, i == 55);
      recv_block(d, f, l, n);
      check("b56_blk1_data", d, {{56{8'h41}}, 8'h80, 56'h0});
      check("b56_blk1_flags", {f, l}, 2'b10);
      recv_block(d, f, l, n);
      check("b56_blk2_data", d, {448'h0, 64'h1C0});
      check("b56_blk2_flags", {f, l}, 2'b01);
      check("b56_msg_bytes", n, 56);

      for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
      held = '0;
      for (int i = 0; i < 64; i++) held[511 - 8*i -: 8] = 8'(i);
      recv_block(d, f, l, n);
      check("b64_blk1_data", d, held);
      check("b64_blk1_flags", {f, l}, 2'b10);
      recv_block(d, f, l, n);
      check("b64_blk2_data", d, {8'h80, 440'h0, 64'h200});
      check("b64_blk2_flags", {f, l}, 2'b01);
      check("b64_msg_bytes", n, 64);

      // Timeout-terminated message: latency counted in edges after the last accept.
      send_abc(1'b0);
      lat = 0;
      while (!blk_valid && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("timeout_latency", lat, 102);
      recv_block(d, f, l, n);
      check("timeout_data", d, exp_abc);
      check("timeout_flags", {f, l}, 2'b11);
      check("timeout_msg_bytes", n, 3);

      // Backpressure: block must hold while blk_ready is low.
      blk_ready = 1'b0;
      send_abc(1'b1);
      lat = 0;
      while (!blk_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      held = blk_data;
      check("bp_data_before", held, exp_abc);
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (blk_data !== held || in_ready !== 1'b0 || blk_valid !== 1'b1) bad = 1'b1;
      end
      check("bp_stable", bad, 0);
      recv_block(d, f, l, n);
      check("bp_data_after", d, exp_abc);

      // Reset while a block is held drops blk_valid at once.
      blk_ready = 1'b0;
      send_abc(1'b1);
      repeat (3) @(negedge clk);
      check("hold_before_rst", blk_valid, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_emit_valid", blk_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      blk_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset in the middle of a message discards it.
      for (int i = 0; i < 10; i++) send_byte(8'h55, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_fill_ready", in_ready, 0);
      check("rst_mid_fill_valid", blk_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_abc(1'b1);
      recv_block(d, f, l, n);
      check("post_rst_data", d, exp_abc);
      check("post_rst_flags", {f, l}, 2'b11);
      check("post_rst_msg_bytes", n, 3);
      check("post_rst_len_err", len_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
